// File: rtl/demux_pkg.sv
// Shared defaults and slot state encoding for the demux_stream block.
package demux_pkg;

   localparam int DEMUX_DW_DEFAULT = 8;
   localparam int DEMUX_N_DEFAULT  = 4;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slot with valid/ready handshake.
//
//   state      | meaning
//   SLOT_EMPTY | no beat held, o_valid low, always able to load
//   SLOT_FULL  | beat held on o_data until the consumer takes it
module demux_slot
   import demux_pkg::*;
#(
   parameter int DW = DEMUX_DW_DEFAULT
) (
   input  logic          i_clk,
   input  logic          i_rstn,
   input  logic          i_load,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [DW-1:0] o_data,
   output logic          o_can_load
);

   slot_state_e   state_q, state_d;
   logic [DW-1:0] data_q, data_d;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= SLOT_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // Data is only written on load, so it stays stable while stalled and
   // keeps its last value after draining.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
         SLOT_EMPTY: begin
            if (i_load) begin
               state_d = SLOT_FULL;
               data_d  = i_data;
            end
         end
         SLOT_FULL: begin
            if (i_load) begin
               state_d = SLOT_FULL;
               data_d  = i_data;
            end else if (i_ready) begin
               state_d = SLOT_EMPTY;
            end
         end
         default: state_d = SLOT_EMPTY;
      endcase
   end

   assign o_valid    = (state_q == SLOT_FULL);
   assign o_can_load = (state_q == SLOT_EMPTY) || i_ready;
   assign o_data     = data_q;

endmodule

// File: rtl/demux_stream.sv
// 1-to-N registered stream demultiplexer with a one-entry slot per channel.
// Optional out-of-range drop counter enabled by DEMUX_STREAM_DROP_CNT_EN.
module demux_stream
   import demux_pkg::*;
#(
   parameter  int DW   = DEMUX_DW_DEFAULT,
   parameter  int N    = DEMUX_N_DEFAULT,
   localparam int SELW = $clog2(N)
) (
   input  logic            i_clk,
   input  logic            i_rstn,
   input  logic            i_in_valid,
   output logic            o_in_ready,
   input  logic [SELW-1:0] i_in_sel,
   input  logic [DW-1:0]   i_in_data,
   output logic [N-1:0]    o_out_valid,
   input  logic [N-1:0]    i_out_ready,
   output logic [N*DW-1:0] o_out_data
`ifdef DEMUX_STREAM_DROP_CNT_EN
   ,
   output logic [7:0]      o_drop_cnt
`endif
);

   logic [N-1:0] sel_oh;
   logic [N-1:0] can_load;
   logic [N-1:0] load;
   logic         in_range;

   for (genvar k = 0; k < N; k++) begin : g_ch
      assign sel_oh[k] = (i_in_sel == SELW'(k));
      assign load[k]   = i_in_valid && sel_oh[k] && can_load[k];

      demux_slot #(.DW(DW)) u_slot (
         .i_clk      (i_clk),
         .i_rstn     (i_rstn),
         .i_load     (load[k]),
         .i_data     (i_in_data),
         .o_valid    (o_out_valid[k]),
         .i_ready    (i_out_ready[k]),
         .o_data     (o_out_data[k*DW +: DW]),
         .o_can_load (can_load[k])
      );
   end

   // Out-of-range selects decode to no channel; those beats are swallowed.
   assign in_range   = |sel_oh;
   assign o_in_ready = in_range ? |(sel_oh & can_load) : 1'b1;

`ifdef DEMUX_STREAM_DROP_CNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (i_in_valid && !in_range && (drop_cnt_q != 8'hFF))
         drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) drop_cnt_q <= '0;
      else         drop_cnt_q <= drop_cnt_d;
   end

   assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Directed and model-checked bench for demux_stream (N=4 main, N=3 for out-of-range selects).
module tb_demux_stream;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_sel;
   logic [7:0]  in_data;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data;

   logic        in_valid3;
   logic        in_ready3;
   logic [1:0]  in_sel3;
   logic [7:0]  in_data3;
   logic [2:0]  out_valid3;
   logic [2:0]  out_ready3;
   logic [23:0] out_data3;

   int checks = 0;
   int errors = 0;

   demux_stream #(.DW(8), .N(4)) dut (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_in_sel    (in_sel),
      .i_in_data   (in_data),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data)
   );

   demux_stream #(.DW(8), .N(3)) dut3 (
      .i_clk       (clk),
      .i_rstn      (rstn),
      .i_in_valid  (in_valid3),
      .o_in_ready  (in_ready3),
      .i_in_sel    (in_sel3),
      .i_in_data   (in_data3),
      .o_out_valid (out_valid3),
      .i_out_ready (out_ready3),
      .o_out_data  (out_data3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] exp_full;
   logic [7:0] exp_data [4];
   logic       exp_rdy;
   logic       acc;

   initial begin
      rstn = 1'b0;
      in_valid = 0; in_sel = 0; in_data = 0; out_ready = 4'hF;
      in_valid3 = 0; in_sel3 = 0; in_data3 = 0; out_ready3 = 3'b000;

      // 1: reset and idle
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(out_valid), 64'h0);
      check("rst_data", 64'(out_data), 64'h0);
      for (int s = 0; s < 4; s++) begin
         in_sel = 2'(s);
         #1;
         check("rst_in_ready", 64'(in_ready), 64'h1);
      end
      @(negedge clk);
      rstn = 1'b1;
      step();
      check("idle_valid", 64'(out_valid), 64'h0);

      // 2: single beat to channel 2
      in_valid = 1; in_sel = 2; in_data = 8'hA5;
      #1;
      check("single_in_ready", 64'(in_ready), 64'h1);
      step();
      in_valid = 0;
      check("single_valid", 64'(out_valid), 64'b0100);
      check("single_data", 64'(out_data[23:16]), 64'hA5);
      step();
      check("single_drained", 64'(out_valid), 64'h0);
      check("single_data_kept", 64'(out_data[23:16]), 64'hA5);

      // 3: backpressure isolation on channel 1
      out_ready = 4'b1101;
      in_valid = 1; in_sel = 1; in_data = 8'h11;
      step();
      check("bp_ch1_valid", 64'(out_valid[1]), 64'h1);
      check("bp_ch1_data", 64'(out_data[15:8]), 64'h11);
      in_data = 8'h22;
      #1;
      check("bp_stall_ready", 64'(in_ready), 64'h0);
      step();
      check("bp_ch1_held", 64'(out_data[15:8]), 64'h11);
      in_sel = 3; in_data = 8'h33;
      #1;
      check("bp_ch3_ready", 64'(in_ready), 64'h1);
      step();
      check("bp_ch3_valid", 64'(out_valid), 64'b1010);
      check("bp_ch3_data", 64'(out_data[31:24]), 64'h33);
      check("bp_ch1_still", 64'(out_data[15:8]), 64'h11);
      in_sel = 1; in_data = 8'h22; out_ready = 4'hF;
      #1;
      check("bp_release_ready", 64'(in_ready), 64'h1);
      step();
      in_valid = 0;
      check("bp_order_valid", 64'(out_valid), 64'b0010);
      check("bp_order_data", 64'(out_data[15:8]), 64'h22);
      step();
      check("bp_empty", 64'(out_valid), 64'h0);

      // 4: full-rate streaming on channel 0
      in_valid = 1; in_sel = 0;
      for (int i = 0; i < 16; i++) begin
         in_data = 8'(i);
         #1;
         check("stream_ready", 64'(in_ready), 64'h1);
         step();
         check("stream_valid", 64'(out_valid), 64'b0001);
         check("stream_data", 64'(out_data[7:0]), 64'(i));
      end
      in_valid = 0;
      step();
      check("stream_end", 64'(out_valid), 64'h0);

      // 5: reset while channel 0 is stalled
      out_ready = 4'b1110;
      in_valid = 1; in_sel = 0; in_data = 8'h5A;
      step();
      in_valid = 0;
      check("mid_full", 64'(out_valid), 64'b0001);
      #2;
      rstn = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'h0);
      check("mid_rst_data", 64'(out_data), 64'h0);
      @(negedge clk);
      rstn = 1'b1;
      step();
      check("mid_after_valid", 64'(out_valid), 64'h0);
      in_sel = 0;
      #1;
      check("mid_after_ready", 64'(in_ready), 64'h1);

      // 6: random traffic against a one-entry-per-channel model
      exp_full = '0;
      for (int k = 0; k < 4; k++) exp_data[k] = 8'h00;
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_sel    = 2'($urandom_range(0, 3));
         in_data   = 8'($urandom);
         out_ready = 4'($urandom);
         #1;
         exp_rdy = !exp_full[in_sel] || out_ready[in_sel];
         check("rnd_in_ready", 64'(in_ready), 64'(exp_rdy));
         check("rnd_valid", 64'(out_valid), 64'(exp_full));
         for (int k = 0; k < 4; k++)
            if (exp_full[k])
               check("rnd_data", 64'(out_data[k*8 +: 8]), 64'(exp_data[k]));
         acc = in_valid && exp_rdy;
         for (int k = 0; k < 4; k++) begin
            if (acc && (in_sel == 2'(k))) begin
               exp_full[k] = 1'b1;
               exp_data[k] = in_data;
            end else if (exp_full[k] && out_ready[k]) begin
               exp_full[k] = 1'b0;
            end
         end
         step();
      end
      in_valid = 0;

      // N=3: out-of-range select is accepted and leaves slots untouched
      in_valid3 = 1; in_sel3 = 0; in_data3 = 8'h77;
      step();
      check("n3_ch0_valid", 64'(out_valid3), 64'b001);
      check("n3_ch0_data", 64'(out_data3[7:0]), 64'h77);
      in_sel3 = 3; in_data3 = 8'h99;
      #1;
      check("n3_oor_ready", 64'(in_ready3), 64'h1);
      step();
      check("n3_oor_valid", 64'(out_valid3), 64'b001);
      check("n3_oor_data", 64'(out_data3), 64'h000077);
      in_sel3 = 0;
      #1;
      check("n3_ch0_stall", 64'(in_ready3), 64'h0);
      in_sel3 = 2;
      #1;
      check("n3_ch2_ready", 64'(in_ready3), 64'h1);
      in_valid3 = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
